// File: rtl/axis_adc_4ch_decimator_if.sv
// axis_adc_4ch_decimator_if: AXI-Stream bus for the decimator; tlast exists only with AXIS_DECIM_TLAST_EN
interface axis_adc_4ch_decimator_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
`ifdef AXIS_DECIM_TLAST_EN
    logic        tlast;
    modport master (output tvalid, output tdata, output tlast, input tready);
`else
    modport master (output tvalid, output tdata, input tready);
`endif
    modport slave (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_adc_4ch_decimator.sv
// axis_adc_4ch_decimator: 4-channel boxcar decimator with shift/saturate; AXIS_DECIM_TLAST_EN adds packet tlast
module axis_adc_4ch_decimator #(
    parameter int CNTR_WIDTH = 16,
    parameter int SAT_WIDTH  = 16
`ifdef AXIS_DECIM_TLAST_EN
    , parameter int PKT_LEN  = 1024
`endif
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_enable,
    input  logic [CNTR_WIDTH-1:0] cfg_ratio,
    input  logic [4:0]            cfg_shift,
    axis_adc_4ch_decimator_if.slave  s_axis,
    axis_adc_4ch_decimator_if.master m_axis,
    output logic                  sts_overflow
);
    localparam int AW = 16 + CNTR_WIDTH;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-SAT_WIDTH+1){1'b0}}, {(SAT_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-SAT_WIDTH+1){1'b1}}, {(SAT_WIDTH-1){1'b0}}};

    logic [0:0]             state_q, state_d;
    logic                   ready_q, ready_d;
    logic [CNTR_WIDTH-1:0]  cnt_q, cnt_d, n_lat_q, n_lat_d;
    logic signed [AW-1:0]   acc_q [4];
    logic signed [AW-1:0]   acc_d [4];
    logic                   valid_q, valid_d;
    logic [63:0]            data_q, data_d;
    logic                   ovf_q, ovf_d;
    logic                   accept, first, done, load;
    logic [CNTR_WIDTH-1:0]  n_cur, cnt_nxt;
    logic signed [AW-1:0]   smp, sh;
    logic [63:0]            result;

    // Block counting, per-channel sums, scale/saturate and the single-entry output register
    always_comb begin
        accept  = state_q == ACC && cfg_enable && s_axis.tvalid && ready_q;
        first   = cnt_q == '0;
        n_cur   = first ? cfg_ratio : n_lat_q;
        cnt_nxt = cnt_q + 1'b1;
        done    = accept && (cnt_nxt == n_cur || n_cur == '0);
        state_d = cfg_enable ? ACC : IDLE;
        ready_d = 1'b1;
        n_lat_d = ((state_q == IDLE && cfg_enable) || (accept && first)) ? cfg_ratio : n_lat_q;
        cnt_d   = (!cfg_enable || done) ? '0 : accept ? cnt_nxt : cnt_q;
        result  = '0;
        smp     = '0;
        sh      = '0;
        for (int c = 0; c < 4; c++) begin
            smp      = {{CNTR_WIDTH{s_axis.tdata[16*c+15]}}, s_axis.tdata[16*c +: 16]};
            acc_d[c] = !accept ? acc_q[c] : first ? smp : acc_q[c] + smp;
            sh       = acc_d[c] >>> cfg_shift;
            result[16*c +: 16] = sh > SMAX ? SMAX[15:0] : sh < SMIN ? SMIN[15:0] : sh[15:0];
        end
        load    = done && (!valid_q || m_axis.tready);
        valid_d = load || (valid_q && !m_axis.tready);
        data_d  = load ? result : data_q;
        ovf_d   = cfg_enable && (ovf_q || (done && !load));
    end

    // State registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            n_lat_q <= '0;
            acc_q   <= '{default: '0};
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            n_lat_q <= n_lat_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s_axis.tready = ready_q;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;
    assign sts_overflow  = ovf_q;

`ifdef AXIS_DECIM_TLAST_EN
    localparam int BW = $clog2(PKT_LEN + 1);
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);
    logic [BW-1:0] beat_q, beat_d;

    // Count accepted output beats; dropped results never reach the register so never count
    always_comb beat_d = !cfg_enable ? '0 : (valid_q && m_axis.tready) ? (beat_q == LAST ? '0 : beat_q + 1'b1) : beat_q;

    // Beat counter register
    always_ff @(posedge aclk) beat_q <= areset ? '0 : beat_d;

    assign m_axis.tlast = beat_q == LAST;
`endif
endmodule

// File: tb/tb_axis_adc_4ch_decimator.sv
// tb_axis_adc_4ch_decimator: randomized bench with a block-level reference model of the decimator
module tb_axis_adc_4ch_decimator;
  localparam int PKT = 3;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_ratio = 16'd1;
  logic [4:0]  cfg_shift = 5'd0;
  logic        sts_overflow;
  int checks = 0;
  int errors = 0;
  axis_adc_4ch_decimator_if s_if();
  axis_adc_4ch_decimator_if m_if();
`ifdef AXIS_DECIM_TLAST_EN
  axis_adc_4ch_decimator #(.PKT_LEN(PKT)) dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_ratio(cfg_ratio),
    .cfg_shift(cfg_shift), .s_axis(s_if), .m_axis(m_if), .sts_overflow(sts_overflow)
  );
`else
  axis_adc_4ch_decimator dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_ratio(cfg_ratio),
    .cfg_shift(cfg_shift), .s_axis(s_if), .m_axis(m_if), .sts_overflow(sts_overflow)
  );
`endif
  always #5 aclk = ~aclk;
  logic [63:0] blk[$];
  int          n_cur = 1;
  bit          running = 0, e_ready = 0, e_valid = 0, e_ovf = 0;
  logic [63:0] e_data = '0;
  int          beat = 0;
  bit          e_tlast;
  function automatic logic [63:0] block_word();
    logic [63:0] w, x;
    longint s;
    w = '0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      foreach (blk[i]) begin
        x = blk[i];
        s += longint'($signed(x[16*c +: 16]));
      end
      s = s >>> cfg_shift;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      w[16*c +: 16] = s[15:0];
    end
    return w;
  endfunction
  function automatic logic [63:0] rnd_small();
    logic [63:0] r;
    int v;
    for (int c = 0; c < 4; c++) begin
      v = int'($urandom_range(2000, 0)) - 1000;
      r[16*c +: 16] = v[15:0];
    end
    return r;
  endfunction
  function automatic logic [63:0] sum2(logic [63:0] a, logic [63:0] b);
    logic [63:0] r;
    int v;
    for (int c = 0; c < 4; c++) begin
      v = int'($signed(a[16*c +: 16])) + int'($signed(b[16*c +: 16]));
      r[16*c +: 16] = v[15:0];
    end
    return r;
  endfunction
  task automatic tick();
    bit done, acc_out;
    logic [63:0] word;
    @(posedge aclk);
    done = 0;
    word = '0;
    if (areset) begin
      blk.delete();
      running = 0; e_ready = 0; e_valid = 0; e_data = '0; e_ovf = 0; beat = 0;
    end else begin
      acc_out = e_valid && m_if.tready;
      if (running && cfg_enable && s_if.tvalid && e_ready) begin
        if (blk.size() == 0) n_cur = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
        blk.push_back(s_if.tdata);
        if (blk.size() == n_cur) begin
          done = 1;
          word = block_word();
          blk.delete();
        end
      end
      if (!cfg_enable) blk.delete();
      running = cfg_enable;
      if (acc_out) begin
        e_valid = 0;
        beat = (beat + 1) % PKT;
      end
      if (done) begin
        if (!e_valid) begin
          e_valid = 1;
          e_data = word;
        end else e_ovf = 1;
      end
      if (!cfg_enable) begin
        e_ovf = 0;
        beat = 0;
      end
      e_ready = 1;
    end
    e_tlast = beat == PKT - 1;
    #1;
  endtask
  task automatic go_idle(int n);
    cfg_enable = 0;
    m_if.tready = 1;
    repeat (n) tick();
  endtask
  task automatic test_reset();
    areset = 1;
    cfg_enable = 0;
    s_if.tvalid = 1;
    s_if.tdata = {$urandom, $urandom};
    m_if.tready = 1;
    repeat (3) tick();
    checks++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tdata !== 64'd0 || sts_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tready=%b tvalid=%b tdata=%h ovf=%b, expected all zero",
               s_if.tready, m_if.tvalid, m_if.tdata, sts_overflow);
    end
    areset = 0;
    tick();
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", s_if.tready);
    end
  endtask
  task automatic test_basic();
    int first_t = -1, words = 0;
    cfg_ratio = 4; cfg_shift = 2; m_if.tready = 1;
    s_if.tdata = {4{16'd1000}};
    cfg_enable = 1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || sts_overflow !== e_ovf || s_if.tready !== e_ready) begin
        errors++;
        $display("FAIL basic_model t=%0d: got v=%b d=%h o=%b expected v=%b d=%h o=%b",
                 t, m_if.tvalid, m_if.tdata, sts_overflow, e_valid, e_data, e_ovf);
      end
      if (m_if.tvalid === 1'b1) begin
        words++;
        if (first_t < 0) first_t = t;
        checks++;
        if (m_if.tdata !== {4{16'h03E8}}) begin
          errors++;
          $display("FAIL basic_lanes: got %h expected %h", m_if.tdata, {4{16'h03E8}});
        end
      end
    end
    checks++;
    if (first_t != 5) begin
      errors++;
      $display("FAIL basic_first_valid: got cycle %0d expected 5", first_t);
    end
    checks++;
    if (words != 4) begin
      errors++;
      $display("FAIL basic_word_count: got %0d expected 4", words);
    end
  endtask
  task automatic test_saturate();
    logic [31:0] r;
    logic [47:0] lanes;
    for (int sh = 0; sh < 2; sh++) begin
      go_idle(2);
      r = $urandom;
      cfg_ratio = 4;
      cfg_shift = 5'(sh);
      s_if.tdata = {r[15:0], 16'hFFFD, 16'h8AD0, 16'h7530};
      lanes = {(sh == 1) ? 16'hFFFA : 16'hFFF4, 16'h8000, 16'h7FFF};
      cfg_enable = 1;
      repeat (12) begin
        tick();
        checks++;
        if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || sts_overflow !== e_ovf) begin
          errors++;
          $display("FAIL sat_model: got v=%b d=%h o=%b expected v=%b d=%h o=%b",
                   m_if.tvalid, m_if.tdata, sts_overflow, e_valid, e_data, e_ovf);
        end
        if (m_if.tvalid === 1'b1) begin
          checks++;
          if (m_if.tdata[47:0] !== lanes) begin
            errors++;
            $display("FAIL sat_lanes shift=%0d: got %h expected %h", sh, m_if.tdata[47:0], lanes);
          end
        end
      end
    end
  endtask
  task automatic test_n1();
    logic [15:0] k16;
    go_idle(2);
    cfg_ratio = 1; cfg_shift = 0; m_if.tready = 1;
    s_if.tdata = '0;
    cfg_enable = 1;
    tick();
    for (int k = 0; k < 32; k++) begin
      k16 = 16'(k);
      cfg_ratio = (k < 16) ? 16'd1 : 16'd0;
      s_if.tdata = {4{k16}};
      tick();
      checks++;
      if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || sts_overflow !== e_ovf) begin
        errors++;
        $display("FAIL n1_model k=%0d: got v=%b d=%h expected v=%b d=%h", k, m_if.tvalid, m_if.tdata, e_valid, e_data);
      end
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== {4{k16}} || sts_overflow !== 1'b0) begin
        errors++;
        $display("FAIL n1_passthrough k=%0d: got v=%b d=%h o=%b expected 1 %h 0",
                 k, m_if.tvalid, m_if.tdata, sts_overflow, {4{k16}});
      end
    end
  endtask
  task automatic test_backpressure();
    logic [63:0] smp [9];
    go_idle(2);
    for (int i = 0; i < 9; i++) smp[i] = rnd_small();
    cfg_ratio = 2; cfg_shift = 0; m_if.tready = 0;
    s_if.tdata = smp[0];
    cfg_enable = 1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      s_if.tdata = smp[i];
      m_if.tready = (i >= 7);
      tick();
      checks++;
      if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || sts_overflow !== e_ovf) begin
        errors++;
        $display("FAIL bp_model i=%0d: got v=%b d=%h o=%b expected v=%b d=%h o=%b",
                 i, m_if.tvalid, m_if.tdata, sts_overflow, e_valid, e_data, e_ovf);
      end
      if (i == 6) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== sum2(smp[1], smp[2]) || sts_overflow !== 1'b1) begin
          errors++;
          $display("FAIL bp_held: got v=%b d=%h o=%b expected 1 %h 1",
                   m_if.tvalid, m_if.tdata, sts_overflow, sum2(smp[1], smp[2]));
        end
      end
      if (i == 8) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== sum2(smp[7], smp[8])) begin
          errors++;
          $display("FAIL bp_resume: got v=%b d=%h expected 1 %h", m_if.tvalid, m_if.tdata, sum2(smp[7], smp[8]));
        end
      end
    end
    cfg_enable = 0;
    tick();
    checks++;
    if (sts_overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf_clear: got %b expected 0", sts_overflow);
    end
  endtask
  task automatic test_ratio_change();
    go_idle(2);
    cfg_ratio = 4; cfg_shift = 0; m_if.tready = 1;
    s_if.tdata = rnd_small();
    cfg_enable = 1;
    tick();
    for (int t = 1; t <= 30; t++) begin
      s_if.tdata = rnd_small();
      if (t == 3) cfg_ratio = 8;
      m_if.tready = !(t >= 13 && t < 18);
      cfg_enable = !(t >= 16 && t < 20);
      tick();
      checks++;
      if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || sts_overflow !== e_ovf) begin
        errors++;
        $display("FAIL ratio_model t=%0d: got v=%b d=%h o=%b expected v=%b d=%h o=%b",
                 t, m_if.tvalid, m_if.tdata, sts_overflow, e_valid, e_data, e_ovf);
      end
      if (t inside {4, 12, 17, 28}) begin
        checks++;
        if (m_if.tvalid !== 1'b1) begin
          errors++;
          $display("FAIL ratio_valid t=%0d: got %b expected 1", t, m_if.tvalid);
        end
      end
      if (t inside {8, 18, 27}) begin
        checks++;
        if (m_if.tvalid !== 1'b0) begin
          errors++;
          $display("FAIL ratio_idle t=%0d: got %b expected 0", t, m_if.tvalid);
        end
      end
    end
  endtask
  task automatic test_random();
    go_idle(2);
    cfg_enable = 1;
    for (int t = 0; t < 400; t++) begin
      s_if.tvalid = ($urandom_range(7, 0) != 0);
      s_if.tdata = {$urandom, $urandom};
      m_if.tready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) cfg_ratio = 16'($urandom_range(5, 0));
      if ($urandom_range(15, 0) == 0) cfg_shift = 5'($urandom_range(4, 0));
      cfg_enable = ($urandom_range(49, 0) != 0);
      tick();
      checks++;
      if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || sts_overflow !== e_ovf) begin
        errors++;
        $display("FAIL random_model t=%0d: got v=%b d=%h o=%b expected v=%b d=%h o=%b",
                 t, m_if.tvalid, m_if.tdata, sts_overflow, e_valid, e_data, e_ovf);
      end
    end
    s_if.tvalid = 1;
  endtask
`ifdef AXIS_DECIM_TLAST_EN
  task automatic test_tlast();
    int nbeat = 0;
    go_idle(2);
    cfg_ratio = 1; cfg_shift = 0;
    cfg_enable = 1;
    tick();
    for (int t = 0; t < 24; t++) begin
      s_if.tdata = {$urandom, $urandom};
      m_if.tready = (t % 2 == 0);
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        nbeat++;
        checks++;
        if (m_if.tlast !== (nbeat % PKT == 0)) begin
          errors++;
          $display("FAIL tlast_beat %0d: got %b expected %b", nbeat, m_if.tlast, (nbeat % PKT == 0));
        end
      end
      tick();
      checks++;
      if (m_if.tvalid !== e_valid || m_if.tdata !== e_data || (e_valid && m_if.tlast !== e_tlast)) begin
        errors++;
        $display("FAIL tlast_model t=%0d: got v=%b d=%h l=%b expected v=%b d=%h l=%b",
                 t, m_if.tvalid, m_if.tdata, m_if.tlast, e_valid, e_data, e_tlast);
      end
    end
    checks++;
    if (nbeat < 9) begin
      errors++;
      $display("FAIL tlast_beat_count: got %0d expected at least 9", nbeat);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_n1();
    test_backpressure();
    test_ratio_change();
    test_random();
`ifdef AXIS_DECIM_TLAST_EN
    test_tlast();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
